// File: rtl/apb_ram_completer_v2.sv
`timescale 1ns/1ps
// apb_ram_completer_v2
// APB completer fronting a single-port on-chip RAM of DEPTH words of
// DATA_WIDTH bits. After reset the array is scrubbed to zero, one word per
// cycle, before any transfer is accepted. Each transfer inserts WAIT_STATES
// PREADY-low access cycles. Misaligned or out-of-range accesses complete
// with PSLVERR=1 and PRDATA=0, and they do not touch the array.
//
// Optional feature macro: APB_RAM_PSTRB_EN adds the PSTRB port and byte-lane
// write enables. Without it, every good write updates the full word.
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESET   in   synchronous active-high reset
//   PSEL     in   completer select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address [ADDR_WIDTH-1:0]
//   PWDATA   in   write data [DATA_WIDTH-1:0]
//   PSTRB    in   byte-lane write enables [DATA_WIDTH/8-1:0] (APB_RAM_PSTRB_EN only)
//   PRDATA   out  registered read data
//   PREADY   out  registered transfer completion
//   PSLVERR  out  registered transfer error, only ever high with PREADY
module apb_ram_completer_v2 #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_RAM_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int B     = $clog2(NB);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Low address bits that must be zero for an aligned access (none when B=0).
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << B) - 1);
    // One extra bit so DEPTH = 2^(ADDR_WIDTH-B) does not wrap to zero.
    localparam logic [ADDR_WIDTH:0]   DEPTH_X    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, DONE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        scrub_cnt;
    logic [3:0]              wait_cnt;
    logic [IDX_W-1:0]        idx_q;
    logic                    write_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;

    // Address decode of the live bus, used at the setup phase.
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [IDX_W-1:0]        cur_idx;
    logic                    addr_err;

    assign word_addr = PADDR >> B;
    assign cur_idx   = word_addr[IDX_W-1:0];
    assign addr_err  = (|(PADDR & ALIGN_MASK)) || ({1'b0, word_addr} >= DEPTH_X);

    // NOTE: the array has no reset; the INIT scrub zeroes it through the
    // normal write port, which keeps it mappable onto a RAM macro.
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Single write port shared by the scrub and the APB completion edge.
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_idx;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NB-1:0]           mem_lane;

    // NOTE: every output of this block gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;
        mem_lane  = strb_q;
        if (!PRESET) begin
            if (state == INIT) begin
                mem_we    = 1'b1;
                mem_idx   = scrub_cnt;
                mem_wdata = '0;
                mem_lane  = '1;
            end else if (state == DONE && write_q && !err_q) begin
                // Commit on the edge leaving DONE; a reset on that edge aborts it.
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (mem_lane[k]) mem[mem_idx][k*8 +: 8] <= mem_wdata[k*8 +: 8];
            end
        end
    end

`ifdef APB_RAM_PSTRB_EN
    always_ff @(posedge PCLK) begin
        if (state == IDLE && PSEL && !PENABLE) strb_q <= PSTRB;
    end
`else
    assign strb_q = '1;
`endif

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples values from before the edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= INIT;
            scrub_cnt <= '0;
            wait_cnt  <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= '0;
        end else begin
            case (state)
                INIT: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    if (scrub_cnt == LAST_IDX) state <= IDLE;
                    else                       scrub_cnt <= scrub_cnt + 1'b1;
                end

                IDLE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    if (PSEL && !PENABLE) begin
                        idx_q    <= cur_idx;
                        write_q  <= PWRITE;
                        err_q    <= addr_err;
                        wdata_q  <= PWDATA;
                        wait_cnt <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            // Straight to completion using the live decode.
                            state   <= DONE;
                            PREADY  <= 1'b1;
                            PSLVERR <= addr_err;
                            if (addr_err)     PRDATA <= '0;
                            else if (!PWRITE) PRDATA <= mem[cur_idx];
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (!PSEL) begin
                        // Requester abandoned the transfer: drop it silently.
                        state <= IDLE;
                    end else if (wait_cnt == 4'd1) begin
                        state   <= DONE;
                        PREADY  <= 1'b1;
                        PSLVERR <= err_q;
                        if (err_q)         PRDATA <= '0;
                        else if (!write_q) PRDATA <= mem[idx_q];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                DONE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_ram_completer_v2.sv
`timescale 1ns/1ps
// Self-checking bench for apb_ram_completer_v2. Two instances are built:
// instance 0 with no wait states, instance 1 with three. A reference model
// (a plain word array per instance plus APB timing arithmetic) predicts each
// completion; expectations go into a scoreboard queue and a monitor compares
// them whenever a DUT raises PREADY.
module tb_apb_ram_completer_v2;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int ND    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0]         preset;
    logic [ND-1:0]         psel;
    logic [ND-1:0]         penable;
    logic [ND-1:0]         pwrite;
    logic [ND-1:0][AW-1:0] paddr;
    logic [ND-1:0][DW-1:0] pwdata;
    logic [ND-1:0][3:0]    pstrb;
    logic [ND-1:0][DW-1:0] prdata;
    logic [ND-1:0]         pready;
    logic [ND-1:0]         pslverr;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        apb_ram_completer_v2 #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .DEPTH      (DEPTH),
            .WAIT_STATES(g == 0 ? 0 : 3)
        ) u_dut (
            .PCLK   (clk),
            .PRESET (preset[g]),
            .PSEL   (psel[g]),
            .PENABLE(penable[g]),
            .PWRITE (pwrite[g]),
            .PADDR  (paddr[g]),
            .PWDATA (pwdata[g]),
`ifdef APB_RAM_PSTRB_EN
            .PSTRB  (pstrb[g]),
`endif
            .PRDATA (prdata[g]),
            .PREADY (pready[g]),
            .PSLVERR(pslverr[g])
        );
    end

    function automatic int ws_of(int d);
        return (d == 0) ? 0 : 3;
    endfunction

    typedef struct {
        int          dut;
        logic        is_read;
        logic        err;
        logic [DW-1:0] rdata;
        int          ready_cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [ND][DEPTH];
    int            cyc;
    int            vectors;
    int            miscompares;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops one expectation per PREADY pulse.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (pready[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_pready", 64'(pready[d]), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("completing_dut", 64'(d), 64'(e.dut));
                    check("latency_cycle", 64'(cyc), 64'(e.ready_cyc));
                    check("pslverr", 64'(pslverr[d]), 64'(e.err));
                    if (e.is_read || e.err) check("prdata", 64'(prdata[d]), 64'(e.rdata));
                end
            end else begin
                check("pslverr_without_pready", 64'(pslverr[d]), 64'd0);
            end
        end
    end

    // Reference rules: word aligned and index below DEPTH.
    function automatic logic addr_bad(input logic [AW-1:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    task automatic clear_model(input int d);
        for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
    endtask

    // Hold reset for two edges, release, and leave the bus at the first legal
    // setup cycle (scrub takes exactly DEPTH cycles after release).
    task automatic do_reset(input int d);
        preset[d]  = 1'b1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1 preset[d] = 1'b0;
        clear_model(d);
        repeat (DEPTH) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full APB transfer; returns 1 ns after the completion edge with the
    // bus still in access phase so a back-to-back setup can follow at once.
    task automatic xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [3:0] strb);
        exp_t       e;
        logic [3:0] lanes;
        int         n;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        pstrb[d]   = strb;
`ifdef APB_RAM_PSTRB_EN
        lanes = strb;
`else
        lanes = 4'hF;
`endif
        e.dut       = d;
        e.is_read   = !wr;
        e.err       = addr_bad(addr);
        e.ready_cyc = cyc + 1 + ws_of(d);
        e.rdata     = '0;
        if (!wr && !e.err) e.rdata = model[d][addr / 4];
        if (wr && !e.err) begin
            for (int k = 0; k < 4; k++)
                if (lanes[k]) model[d][addr / 4][k*8 +: 8] = wdata[k*8 +: 8];
        end
        sb.push_back(e);
        @(posedge clk);
        #1 penable[d] = 1'b1;
        // Data changes during the access phase must be ignored.
        pwdata[d] = $urandom();
        pstrb[d]  = 4'($urandom());
        n = 0;
        forever begin
            @(negedge clk);
            if (pready[d] === 1'b1) break;
            n++;
            if (n > 40) begin
                check("pready_timeout", 64'(pready[d]), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return AW'(4 * $urandom_range(0, DEPTH - 1));
        else if (r == 7) return AW'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        else if (r == 8) return AW'(4 * $urandom_range(DEPTH, 4 * DEPTH));
        else             return AW'($urandom() | 32'h0001_0000);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        preset      = '1;
        psel        = '0;
        penable     = '0;
        pwrite      = '0;
        paddr       = '0;
        pwdata      = '0;
        pstrb       = '1;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("reset_pready", 64'(pready[d]), 64'd0);
            check("reset_pslverr", 64'(pslverr[d]), 64'd0);
            check("reset_prdata", 64'(prdata[d]), 64'd0);
        end

        // Scrub, then read word 5 at the first legal cycle.
        fork
            do_reset(0);
            do_reset(1);
        join
        xfer(0, 1'b0, 32'h14, '0, 4'hF);
        idle(0, 1);
        xfer(1, 1'b0, 32'h14, '0, 4'hF);
        idle(1, 1);

        // Write/read with three wait states.
        xfer(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        idle(1, 1);
        xfer(1, 1'b0, 32'h10, '0, 4'hF);
        check("deadbeef_readback", 64'(prdata[1]), 64'hDEAD_BEEF);
        idle(1, 2);

        // Out-of-range and misaligned writes, then word 1 still zero.
        xfer(1, 1'b1, 32'h100, 32'h1111_2222, 4'hF);
        xfer(1, 1'b1, 32'h06, 32'h3333_4444, 4'hF);
        xfer(1, 1'b0, 32'h04, '0, 4'hF);
        idle(1, 1);

`ifdef APB_RAM_PSTRB_EN
        xfer(1, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF);
        xfer(1, 1'b1, 32'h0, 32'h1234_5678, 4'b0101);
        xfer(1, 1'b0, 32'h0, '0, 4'hF);
        check("strobe_merge", 64'(prdata[1]), 64'hFF34_FF78);
        xfer(1, 1'b1, 32'h0, 32'h0BAD_0BAD, 4'b0000);
        xfer(1, 1'b0, 32'h0, '0, 4'hF);
        idle(1, 1);
`endif

        // Eight back-to-back alternating transfers with no wait states.
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] a;
            a = AW'(4 * $urandom_range(0, DEPTH - 1));
            xfer(0, 1'b1, a, $urandom(), 4'hF);
            xfer(0, 1'b0, a, '0, 4'hF);
        end
        idle(0, 1);

        // Requester drops PSEL mid-wait: the write must leave no trace.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h30; pwdata[1] = 32'h0BAD_F00D; pstrb[1] = 4'hF;
        @(posedge clk); #1 penable[1] = 1'b1;
        @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
        idle(1, 3);
        xfer(1, 1'b0, 32'h30, '0, 4'hF);
        idle(1, 1);

        // Reset during the wait state of a write.
        xfer(1, 1'b1, 32'h20, 32'h5A5A_0001, 4'hF);
        xfer(1, 1'b0, 32'h20, '0, 4'hF);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h8; pwdata[1] = 32'hA5A5_A5A5; pstrb[1] = 4'hF;
        @(posedge clk); #1 penable[1] = 1'b1; preset[1] = 1'b1;
        @(negedge clk);
        check("pre_reset_prdata_held", 64'(prdata[1]), 64'h5A5A_0001);
        @(negedge clk);
        check("midreset_pready", 64'(pready[1]), 64'd0);
        check("midreset_pslverr", 64'(pslverr[1]), 64'd0);
        check("midreset_prdata", 64'(prdata[1]), 64'd0);
        do_reset(1);
        xfer(1, 1'b0, 32'h8, '0, 4'hF);
        xfer(1, 1'b0, 32'h20, '0, 4'hF);
        idle(1, 1);

        // Randomised traffic on both instances.
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 60; i++) begin
                xfer(d, 1'($urandom()), rand_addr(), $urandom(), 4'($urandom()));
                if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 2));
            end
            idle(d, 2);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
